// File: rtl/rv32m_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and default widths.
package rv32m_muldiv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Divide-class ops all have funct3[2] set; remainder ops also have funct3[1].
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage

// File: rtl/rv32m_muldiv_sign_fix.sv
// Two-lane conditional two's-complement negation. Used on the way in to turn
// signed operands into magnitudes, and on the way out to restore the sign of
// the product / quotient / remainder.
// Ports:
//   a_in/neg_a -> a_out : lane A (width WA), negated when neg_a is set
//   b_in/neg_b -> b_out : lane B (width WB), negated when neg_b is set
module rv32m_muldiv_sign_fix #(
    parameter int WA = 32,
    parameter int WB = 32
) (
    input  logic [WA-1:0] a_in,
    input  logic          neg_a,
    input  logic [WB-1:0] b_in,
    input  logic          neg_b,
    output logic [WA-1:0] a_out,
    output logic [WB-1:0] b_out
);

    assign a_out = neg_a ? (~a_in + WA'(1)) : a_in;
    assign b_out = neg_b ? (~b_in + WB'(1)) : b_in;

endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit (EX stage).
// One bit per clock: radix-2 shift-add multiply, restoring divide.
// Divide-by-zero and signed overflow complete straight from IDLE.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : launch an op (only looked at in IDLE)
//   funct3          : M-extension op select
//   op_a, op_b      : rs1 / rs2 data
//   rd_in           : destination register index
//   flush           : synchronous abort back to IDLE
//   busy            : high whenever not IDLE
//   valid_out       : one-cycle result strobe
//   result, rd_out  : result and destination, held until next completion
module rv32m_muldiv
    import rv32m_muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            valid_out,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [4:0]          rd_q, rd_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [XLEN-1:0]     b_mag_q, b_mag_d;
    // Multiply: high half accumulates, low half shifts the multiplier out.
    logic [2*XLEN-1:0]   prod_q, prod_d;
    // Divide: dividend shifts out of quo_q's MSB while quotient bits enter its LSB.
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          rd_out_q, rd_out_d;

    // ---------------- input conditioning ----------------
    logic            in_signed_a, in_signed_b;
    logic            in_neg_a, in_neg_b;
    logic [XLEN-1:0] a_mag, b_mag;

    assign in_signed_a = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    assign in_signed_b = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                         (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign in_neg_a    = in_signed_a & op_a[XLEN-1];
    assign in_neg_b    = in_signed_b & op_b[XLEN-1];

    rv32m_muldiv_sign_fix #(.WA(XLEN), .WB(XLEN)) u_in_fix (
        .a_in  (op_a),
        .neg_a (in_neg_a),
        .b_in  (op_b),
        .neg_b (in_neg_b),
        .a_out (a_mag),
        .b_out (b_mag)
    );

    logic div_by_zero, signed_ovf;
    assign div_by_zero = f3_is_div(funct3) && (op_b == '0);
    assign signed_ovf  = f3_is_div(funct3) && !funct3[0] &&
                         (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

    // ---------------- one iteration ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   rem_next, quo_next;

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_mag_q} : '0);
    assign mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_mag_q};
    assign div_ge    = ~div_diff[XLEN];
    assign rem_next  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign quo_next  = {quo_q[XLEN-2:0], div_ge};

    // ---------------- output conditioning ----------------
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   div_fixed;
    logic              is_rem_q;

    assign is_rem_q = f3_is_rem(funct3_q);

    rv32m_muldiv_sign_fix #(.WA(2*XLEN), .WB(XLEN)) u_out_fix (
        .a_in  (mul_next),
        .neg_a (sign_a_q ^ sign_b_q),
        .b_in  (is_rem_q ? rem_next : quo_next),
        .neg_b (is_rem_q ? sign_a_q : (sign_a_q ^ sign_b_q)),
        .a_out (prod_fixed),
        .b_out (div_fixed)
    );

    logic [XLEN-1:0] final_result;
    always_comb begin
        final_result = div_fixed;
        case (funct3_q)
            F3_MUL:                       final_result = prod_fixed[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_result = prod_fixed[2*XLEN-1:XLEN];
            default:                      final_result = div_fixed;
        endcase
    end

    // ---------------- FSM / datapath next state ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_mag_d  = b_mag_q;
        prod_d   = prod_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        if (flush) begin
            // Abort wins over everything, including a start in the same cycle.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        funct3_d = funct3;
                        rd_d     = rd_in;
                        sign_a_d = in_neg_a;
                        sign_b_d = in_neg_b;
                        b_mag_d  = b_mag;
                        prod_d   = {{XLEN{1'b0}}, a_mag};
                        quo_d    = a_mag;
                        rem_d    = '0;
                        cnt_d    = '0;
                        if (div_by_zero) begin
                            result_d = f3_is_rem(funct3) ? op_a : '1;
                            rd_out_d = rd_in;
                            state_d  = S_DONE;
                        end else if (signed_ovf) begin
                            result_d = f3_is_rem(funct3) ? '0 : op_a;
                            rd_out_d = rd_in;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (f3_is_div(funct3_q)) begin
                        quo_d = quo_next;
                        rem_d = rem_next;
                    end else begin
                        prod_d = mul_next;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        result_d = final_result;
                        rd_out_d = rd_q;
                        state_d  = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_mag_q  <= '0;
            prod_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_mag_q  <= b_mag_d;
            prod_q   <= prod_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign valid_out = (state_q == S_DONE);
    assign result    = result_q;
    assign rd_out    = rd_out_q;

endmodule
